// File: rtl/fetch_controller.sv
// fetch_controller: program loader plus single-cycle instruction fetch unit.
// The block owns an external instruction memory: while loading, it writes
// words at consecutive addresses. While running, it reads at pc and registers
// each fetched instruction. Redirects are taken only in builds that define
// FETCH_BRANCH_EN. Without that macro, pc advances by 4 after each fetch.
module fetch_controller #(
  parameter int          DEPTH    = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int              PTR_W   = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH);
  localparam logic [29:0]      WORDS   = 30'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic             in_range;
  logic             fetch_en;
  logic             run_entry;
  logic [31:0]      pc_nxt;

  // Fetch counter that sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_range  = (pc[31:2] < WORDS);
  assign fetch_en  = (state == RUN) && in_range && !stall;
  assign run_entry = ((state == IDLE) || (state == HALT)) && (state_nxt == RUN);

`ifdef FETCH_BRANCH_EN
  // A redirect replaces the sequential pc; the target is word-aligned.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];
  assign pc_nxt = branch_taken ? {branch_target[31:2], 2'b00} : pc + 32'd4;
`else
  // Branch inputs are ignored in this build.
  logic unused_branch;
  assign unused_branch = ^{branch_taken, branch_target};
  assign pc_nxt = pc + 32'd4;
`endif

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection; a loader offer wins over start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = LOAD;
               else if (start) state_nxt = RUN;
      LOAD:    if (!load_valid) state_nxt = IDLE;
      RUN:     if (!in_range) state_nxt = HALT;
      HALT:    if (load_valid) state_nxt = LOAD;
               else if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port steering: the loader owns the port only in LOAD.
  always_comb begin
    load_ready = (state == LOAD) && (ptr < PTR_MAX);
    mem_we     = load_ready && load_valid;
    mem_addr   = (state == LOAD) ? 32'({ptr, 2'b00}) : pc;
    mem_wdata  = (state == LOAD) ? load_data : 32'h0;
    halted     = (state == HALT);
  end

  // Load pointer: advances per accepted word, cleared when LOAD exits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (state == LOAD) begin
      if (!load_valid)     ptr <= '0;
      else if (load_ready) ptr <= ptr + PTR_W'(1);
    end
  end

  // Fetch stage: registers the instruction read at pc, then advances pc.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 16'h0;
    end else if (run_entry) begin
      pc          <= RESET_PC;
      fetch_count <= 16'h0;
      instr_valid <= 1'b0;
    end else if (state == RUN) begin
      if (!in_range) begin
        instr_valid <= 1'b0;
      end else if (fetch_en) begin
        instr       <= mem_rdata;
        instr_valid <= 1'b1;
        pc          <= pc_nxt;
        fetch_count <= sat_inc(fetch_count);
      end
    end else if (state == HALT) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: external instruction memory, reference
// model of loader/fetch behaviour, directed and randomized steps.
module tb_fetch_controller;

  localparam int          DEPTH    = 10;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  // Instruction memory seen by the DUT.
  logic [31:0] imem [0:255] = '{default: 32'h0};
  int          wr_count = 0;

  // Reference model state.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [15:0] m_count;
  logic [31:0] ref_mem [0:255];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fetch_controller #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clock = ~clock;

  assign mem_rdata = imem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (mem_we) begin
      imem[mem_addr[9:2]] <= mem_wdata;
      wr_count            <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},    m_pc, m_pc === pc ? pc : pc);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_pc"},     pc, m_pc);
    chk({tag, "_instr"},  instr, m_instr);
    chk({tag, "_valid"},  32'(instr_valid), 32'(m_valid));
    chk({tag, "_count"},  32'(fetch_count), 32'(m_count));
    chk({tag, "_halted"}, 32'(halted), 32'(m_mode == M_HALT));
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_pc    = RESET_PC;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_count = 16'h0;
  endtask

  // Called at a falling edge with the model in IDLE or HALT.
  task automatic do_load(input int n, input logic with_start);
    int wr0;
    load_valid = 1'b1;
    start      = with_start;
    load_data  = $urandom;
    @(negedge clock);
    start  = 1'b0;
    m_mode = M_LOAD;
    wr0    = wr_count;
    for (int i = 0; i < n; i++) begin
      load_data  = $urandom;
      load_valid = 1'b1;
      #1;
      chk("load_ready", 32'(load_ready), 32'(i < DEPTH));
      chk("load_we",    32'(mem_we),     32'(i < DEPTH));
      if (i < DEPTH) begin
        chk("load_addr", mem_addr, 32'(i * 4));
        ref_mem[i] = load_data;
      end
      @(negedge clock);
    end
    load_valid = 1'b0;
    @(negedge clock);
    m_mode = M_IDLE;
    chk("load_exit_ready", 32'(load_ready), 32'h0);
    chk("load_writes", 32'(wr_count - wr0), 32'((n < DEPTH) ? n : DEPTH));
  endtask

  task automatic start_cycle();
    start = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    m_mode  = M_RUN;
    m_pc    = RESET_PC;
    m_count = 16'h0;
    m_valid = 1'b0;
    compare_model("start");
  endtask

  task automatic run_cycle(input logic s, input logic b, input logic [31:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    #1;
    chk("run_addr",  mem_addr, m_pc);
    chk("run_we",    32'(mem_we), 32'h0);
    chk("run_wdata", mem_wdata, 32'h0);
    if (m_mode == M_RUN) begin
      if (m_pc[31:2] >= 30'(DEPTH)) begin
        m_mode  = M_HALT;
        m_valid = 1'b0;
      end else if (!s) begin
        m_instr = ref_mem[m_pc[9:2]];
        m_valid = 1'b1;
        m_pc    = (BR_EN && b) ? (t & 32'hFFFF_FFFC) : m_pc + 32'd4;
        m_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
      end
    end
    @(negedge clock);
    stall        = 1'b0;
    branch_taken = 1'b0;
    compare_model("run");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    reset         = 1'b0;
    start         = 1'b0;
    load_valid    = 1'b0;
    load_data     = 32'h0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();

    // Reset values while reset is held.
    #3;
    chk("rst_pc",     pc, RESET_PC);
    chk("rst_instr",  instr, 32'h0);
    chk("rst_valid",  32'(instr_valid), 32'h0);
    chk("rst_count",  32'(fetch_count), 32'h0);
    chk("rst_ready",  32'(load_ready), 32'h0);
    chk("rst_we",     32'(mem_we), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Load three words, start, fetch them with a stall in the middle.
    do_load(3, 1'b0);
    chk("imem_w0", imem[0], ref_mem[0]);
    chk("imem_w2", imem[2], ref_mem[2]);
    start_cycle();
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("seq_instr_a", instr, ref_mem[0]);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("seq_pc_8", pc, 32'd8);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1, 1'b1, 32'($urandom_range(0, 39)));
      chk("stall_pc", pc, 32'd8);
    end
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("release_pc", pc, 32'd12);
    chk("release_instr", instr, ref_mem[2]);

    // Run off the end of memory into HALT.
    for (int k = 0; k < 40 && m_mode != M_HALT; k++) run_cycle(1'b0, 1'b0, 32'h0);
    chk("halt_flag",  32'(halted), 32'h1);
    chk("halt_valid", 32'(instr_valid), 32'h0);
    chk("halt_count", 32'(fetch_count), 32'd10);

    // Restart and redirect to an unaligned target.
    start_cycle();
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b1, 32'h7);
    chk("branch_pc", pc, BR_EN ? 32'd4 : 32'd8);
    chk("branch_instr", instr, ref_mem[1]);

    // Randomized run with stalls and redirects; restart after each halt.
    for (int k = 0; k < 120; k++) begin
      if (m_mode == M_HALT) start_cycle();
      else run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     32'($urandom_range(0, 47)));
    end
    for (int k = 0; k < 40 && m_mode != M_HALT; k++) run_cycle(1'b0, 1'b0, 32'h0);
    chk("halt_again", 32'(halted), 32'h1);

    // Over-long load from HALT with start also high: loader wins.
    do_load(12, 1'b1);
    chk("imem_w9", imem[9], ref_mem[9]);
    chk("imem_w10_untouched", imem[10], 32'h0);

    // Asynchronous reset in the middle of RUN.
    start_cycle();
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc",     pc, RESET_PC);
    chk("arst_instr",  instr, 32'h0);
    chk("arst_valid",  32'(instr_valid), 32'h0);
    chk("arst_count",  32'(fetch_count), 32'h0);
    chk("arst_ready",  32'(load_ready), 32'h0);
    chk("arst_we",     32'(mem_we), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    start_cycle();
    run_cycle(1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 32'h0);
    chk("after_rst_instr", instr, ref_mem[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
